mdu_ctrl: RTL and testbench

- Multi-cycle multiply/divide sequencer that owns the HI/LO register pair for the MIPS pipeline.
- Executes MULT/MULTU/DIV/DIVU iteratively, one bit per cycle, and performs MTHI/MTLO writes.
- Sits beside the single-cycle ALU in EX. The hazard logic stalls the pipeline on busy when the next instruction is an MDU op or MFHI/MFLO.
- HI/LO are always readable combinationally for MFHI/MFLO.

---
 rtl/mdu_ctrl_if.sv | 25 ++
 rtl/mdu_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_mdu_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mdu_ctrl_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
// The master drives ops in; the slave returns HI/LO and status.
interface mdu_ctrl_if #(
  parameter int unsigned DATA_W = 32
);
  logic              start;
  logic [2:0]        op;
  logic [DATA_W-1:0] in1;
  logic [DATA_W-1:0] in2;
  logic              flush;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start, op, in1, in2, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, in1, in2, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// One bit per cycle in CALC; sign fix-up and writeback in FIX.
module mdu_ctrl #(
  parameter int unsigned DATA_W = 32
) (
  input logic    clk,
  input logic    reset,
  mdu_ctrl_if.slave mdu
);

  localparam int unsigned CW = $clog2(DATA_W);
  localparam int unsigned AW = 2 * DATA_W;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic              div_q, div_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic              dz_q, dz_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              is_md;
  logic              is_mthi;
  logic              is_mtlo;
  logic              sgn_op;
  logic              div_op;
  logic              a_neg;
  logic              b_neg;
  logic              b_zero;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;

  always_comb begin
    is_md   = ~mdu.op[2];
    is_mthi = (mdu.op == 3'd4);
    is_mtlo = (mdu.op == 3'd5);
    sgn_op  = ~mdu.op[0];
    div_op  = mdu.op[1];
    a_neg   = sgn_op & mdu.in1[DATA_W-1];
    b_neg   = sgn_op & mdu.in2[DATA_W-1];
    b_zero  = (mdu.in2 == '0);
    a_mag   = a_neg ? (~mdu.in1 + 1'b1) : mdu.in1;
    b_mag   = b_neg ? (~mdu.in2 + 1'b1) : mdu.in2;
  end

  // Multiply step: add multiplicand into the upper half, shift right.
  logic [DATA_W:0]   mul_sum;
  logic [AW-1:0]     mul_nxt;

  always_comb begin
    mul_sum = {1'b0, acc_q[AW-1:DATA_W]}
            + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_nxt = {mul_sum, acc_q[DATA_W-1:1]};
  end

  // Divide step: restoring trial subtract on {rem, next dividend bit}.
  logic [DATA_W:0]   div_t;
  logic [DATA_W+1:0] div_diff;
  logic              div_ge;
  logic [DATA_W-1:0] div_rem;
  logic [AW-1:0]     div_nxt;

  always_comb begin
    div_t    = acc_q[AW-1:DATA_W-1];
    div_diff = {1'b0, div_t} - {2'b00, opnd_q};
    div_ge   = ~div_diff[DATA_W+1];
    div_rem  = div_ge ? div_diff[DATA_W-1:0] : div_t[DATA_W-1:0];
    div_nxt  = {div_rem, acc_q[DATA_W-2:0], div_ge};
  end

  logic [AW-1:0]     prod;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] rem;

  always_comb begin
    prod = qneg_q ? (~acc_q + 1'b1) : acc_q;
    quo  = acc_q[DATA_W-1:0];
    rem  = acc_q[AW-1:DATA_W];
    if (qneg_q) quo = ~quo + 1'b1;
    if (rneg_q) rem = ~rem + 1'b1;
    if (dz_q)   quo = '1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    div_d   = div_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mdu.start && !mdu.flush) begin
          unique case (1'b1)
            is_md: begin
              state_d = CALC;
              cnt_d   = '0;
              div_d   = div_op;
              dz_d    = div_op & b_zero;
              rneg_d  = div_op & a_neg;
              qneg_d  = (a_neg ^ b_neg) & ~(div_op & b_zero);
              if (div_op) begin
                acc_d  = {{DATA_W{1'b0}}, a_mag};
                opnd_d = b_mag;
              end else begin
                acc_d  = {{DATA_W{1'b0}}, b_mag};
                opnd_d = a_mag;
              end
            end
            is_mthi: hi_d = mdu.in1;
            is_mtlo: lo_d = mdu.in1;
            default: ;
          endcase
        end
      end
      CALC: begin
        acc_d = div_q ? div_nxt : mul_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (div_q) begin
          hi_d = rem;
          lo_d = quo;
        end else begin
          {hi_d, lo_d} = prod;
        end
      end
      default: state_d = IDLE;
    endcase

    // Cancel discards the op without touching HI/LO.
    if (mdu.flush && state_q != IDLE) begin
      state_d = IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      div_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      div_q   <= div_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign mdu.busy = busy_q;
  assign mdu.done = done_q;
  assign mdu.hi   = hi_q;
  assign mdu.lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: results, latency, ignore, flush, reset.
// Inputs and samples both happen on the falling edge.
module tb_mdu_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mdu_ctrl_if #(.DATA_W(32)) bus ();

  mdu_ctrl #(.DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] MULT  = 3'd0;
  localparam logic [2:0] MULTU = 3'd1;
  localparam logic [2:0] DIV   = 3'd2;
  localparam logic [2:0] DIVU  = 3'd3;
  localparam logic [2:0] MTHI  = 3'd4;
  localparam logic [2:0] MTLO  = 3'd5;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.in1   = a;
    bus.in2   = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic issue(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    @(negedge clk);
    drive(op, a, b);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic finish_md(string tag, int pre,
                           logic [31:0] eh, logic [31:0] el);
    int n;
    wait_done(n);
    check({tag, "_cyc"}, 64'(n + pre), 64'd33);
    check({tag, "_done"}, 64'(bus.done), 64'd1);
    check({tag, "_hi"}, 64'(bus.hi), 64'(eh));
    check({tag, "_lo"}, 64'(bus.lo), 64'(el));
  endtask

  task automatic run_md(string tag, logic [2:0] op, logic [31:0] a,
                        logic [31:0] b, logic [31:0] eh, logic [31:0] el);
    issue(op, a, b);
    finish_md(tag, 0, eh, el);
    @(negedge clk);
    check({tag, "_dpulse"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    int ndone;
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.in1   = '0;
    bus.in2   = '0;
    bus.flush = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    reset = 1'b0;

    run_md("mult", MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_md("multu", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'hFFFFFFFE, 32'h00000001);
    run_md("div", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_md("divu", DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_md("divz", DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF);
    run_md("sdivz", DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
    run_md("divovf", DIV, 32'h80000000, 32'hFFFFFFFF,
           32'h00000000, 32'h80000000);

    issue(MTHI, 32'h12345678, 32'd0);
    check("mthi_hi", 64'(bus.hi), 64'h12345678);
    check("mthi_busy", {63'd0, bus.busy | bus.done}, 64'd0);
    drive(MTLO, 32'hCAFEF00D, 32'd0);
    check("mtlo_lo", 64'(bus.lo), 64'hCAFEF00D);
    check("mtlo_hi", 64'(bus.hi), 64'h12345678);
    check("mtlo_busy", {63'd0, bus.busy | bus.done}, 64'd0);

    issue(3'd6, 32'hDEADBEEF, 32'd1);
    check("rsvd_busy", 64'(bus.busy), 64'd0);
    check("rsvd_hilo", {bus.hi, bus.lo}, 64'h12345678CAFEF00D);

    issue(MULT, 32'd2, 32'd3);
    repeat (3) @(negedge clk);
    drive(DIV, 32'd9, 32'd3);
    finish_md("ign", 4, 32'd0, 32'd6);
    drive(DIV, 32'd9, 32'd3);
    finish_md("b2b", 0, 32'd0, 32'd3);

    issue(MTHI, 32'd1, 32'd0);
    issue(MTLO, 32'd2, 32'd0);
    issue(MULT, 32'd4, 32'd4);
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("fl_busy", 64'(bus.busy), 64'd0);
    check("fl_hilo", {bus.hi, bus.lo}, {32'd1, 32'd2});
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("fl_nodone", 64'(ndone), 64'd0);
    check("fl_hilo2", {bus.hi, bus.lo}, {32'd1, 32'd2});

    bus.flush = 1'b1;
    drive(MTHI, 32'h55, 32'd0);
    bus.flush = 1'b0;
    check("flst_hi", 64'(bus.hi), 64'd1);
    check("flst_busy", 64'(bus.busy), 64'd0);

    issue(MULT, 32'd4, 32'd4);
    repeat (10) @(negedge clk);
    check("rmid_busy", 64'(bus.busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("rmid_hilo", {bus.hi, bus.lo}, 64'd0);
    check("rmid_bz", {62'd0, bus.busy, bus.done}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("rmid_idle", {62'd0, bus.busy, bus.done}, 64'd0);

    run_md("after", MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
